// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the per-line memory-slot sequencer.
//   - VIC_* cycle-type codes driven on cycle_type
//   - chip model codes used to index the idle-placement tables
//   - default sprite count and idle placement vectors
//   - small helpers for phase classification and table lookup
package cycle_sequencer_pkg;

   localparam int NUM_SPRITES_DEF = 8;

   // One nibble per chip model; nibble 0 belongs to chip code 0.
   localparam logic [15:0] IDLE_PRE_DEF  = {4'd2, 4'd3, 4'd3, 4'd2};
   localparam logic [15:0] IDLE_POST_DEF = {4'd0, 4'd0, 4'd1, 4'd0};

   localparam logic [1:0] CHIP_6569R3   = 2'd0;
   localparam logic [1:0] CHIP_6567R8   = 2'd1;
   localparam logic [1:0] CHIP_6567R56A = 2'd2;
   localparam logic [1:0] CHIP_6569R1   = 2'd3;

   // Low-phase codes occupy 0..5 so the phase test is a single compare.
   localparam logic [3:0] VIC_LP   = 4'd0;
   localparam logic [3:0] VIC_LPI2 = 4'd1;
   localparam logic [3:0] VIC_LS2  = 4'd2;
   localparam logic [3:0] VIC_LR   = 4'd3;
   localparam logic [3:0] VIC_LG   = 4'd4;
   localparam logic [3:0] VIC_LI   = 4'd5;
   localparam logic [3:0] VIC_HPI1 = 4'd6;
   localparam logic [3:0] VIC_HPI3 = 4'd7;
   localparam logic [3:0] VIC_HS1  = 4'd8;
   localparam logic [3:0] VIC_HS3  = 4'd9;
   localparam logic [3:0] VIC_HRI  = 4'd10;
   localparam logic [3:0] VIC_HRC  = 4'd11;
   localparam logic [3:0] VIC_HRX  = 4'd12;
   localparam logic [3:0] VIC_HGC  = 4'd13;
   localparam logic [3:0] VIC_HGI  = 4'd14;
   localparam logic [3:0] VIC_HI   = 4'd15;

   function automatic logic is_low_phase(input logic [3:0] ct);
      return (ct <= VIC_LI);
   endfunction

   function automatic logic [3:0] nibble_sel(input logic [15:0] vec, input logic [1:0] idx);
      logic [3:0] r;
      case (idx)
         2'd0:    r = vec[3:0];
         2'd1:    r = vec[7:4];
         2'd2:    r = vec[11:8];
         default: r = vec[15:12];
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cycle_seq_if.sv
// Bundle between raster/bus-access logic and the cycle sequencer.
//   master: drives chip, phase strobes, sprite DMA enables, badline,
//           cycle_num, ext_req; observes the slot outputs.
//   slave : the sequencer; produces cycle_type, sprite_cnt, refresh_cnt,
//           idle_cnt and ext_grant.
interface cycle_seq_if #(
   parameter int NUM_SPRITES = 8
);
   localparam int SPR_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

   logic [1:0]             chip;
   logic                   clk_phi;
   logic                   phi_phase_start_0;
   logic [NUM_SPRITES-1:0] sprite_dma;
   logic                   badline;
   logic [6:0]             cycle_num;
   logic                   ext_req;

   logic [3:0]             cycle_type;
   logic [SPR_W-1:0]       sprite_cnt;
   logic [2:0]             refresh_cnt;
   logic [3:0]             idle_cnt;
   logic                   ext_grant;

   modport master (
      output chip, clk_phi, phi_phase_start_0, sprite_dma, badline, cycle_num, ext_req,
      input  cycle_type, sprite_cnt, refresh_cnt, idle_cnt, ext_grant
   );

   modport slave (
      input  chip, clk_phi, phi_phase_start_0, sprite_dma, badline, cycle_num, ext_req,
      output cycle_type, sprite_cnt, refresh_cnt, idle_cnt, ext_grant
   );
endinterface

// File: rtl/cycle_sequencer_idle_slot_arbiter.sv
// Idle-slot arbiter: decides when an idle run is complete and hands idle
// low phases to extension DMA.
//   clk_dot4x, rst : clock / synchronous active-high reset
//   advance        : sequencer state update takes effect this edge
//   enter_li       : the update lands in LI
//   ext_req        : extension DMA request
//   post_idle      : current idle run sits between sprites and refresh
//   idle_cnt       : current idle counter
//   idle_target    : pre-idle length for the latched chip
//   idle_done      : idle run ends on this HI
//   ext_grant      : extension owns the current low phase
module idle_slot_arbiter (
   input  logic       clk_dot4x,
   input  logic       rst,
   input  logic       advance,
   input  logic       enter_li,
   input  logic       ext_req,
   input  logic       post_idle,
   input  logic [3:0] idle_cnt,
   input  logic [3:0] idle_target,
   output logic       idle_done,
   output logic       ext_grant
);
   logic ext_grant_d;
   logic ext_grant_q;

   // Every update rewrites the grant, so it can only survive through LI.
   always_comb begin
      ext_grant_d = ext_grant_q;
      if (advance) begin
         ext_grant_d = enter_li & ext_req;
      end
   end

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         ext_grant_q <= 1'b0;
      end else begin
         ext_grant_q <= ext_grant_d;
      end
   end

   // Post-idle counts down to zero; pre-idle counts up to the chip's length.
   assign idle_done = post_idle ? (idle_cnt == 4'd0) : (idle_cnt == idle_target);
   assign ext_grant = ext_grant_q;
endmodule

// File: rtl/cycle_sequencer.sv
// Per-line memory-access slot sequencer (sprite, refresh, graphics, idle).
//   clk_dot4x : dot clock x4
//   rst       : synchronous active-high reset
//   bus       : cycle_seq_if slave port (phase strobes, line inputs,
//               slot outputs and extension DMA grant)
//
// state | meaning
// ------+-------------------------------------------------
// LP    | sprite pointer fetch, low phase
// HS1   | sprite data byte 1, high phase (sprite DMA on)
// LS2   | sprite data byte 2, low phase
// HS3   | sprite data byte 3, high phase
// HPI1  | sprite slot idle, high phase (sprite DMA off)
// LPI2  | sprite slot idle, low phase
// HPI3  | sprite slot idle, high phase
// LR    | refresh, low phase
// HRI   | high phase after a non-final refresh
// HRC   | high phase after final refresh, c-access (badline)
// HRX   | high phase after final refresh, no c-access
// LG    | graphics fetch, low phase
// HGC   | c-access, high phase (badline)
// HGI   | no c-access, high phase
// HI    | idle, high phase
// LI    | idle, low phase (may be granted to extension DMA)
module cycle_sequencer
   import cycle_sequencer_pkg::*;
#(
   parameter int          NUM_SPRITES    = NUM_SPRITES_DEF,
   parameter int          NUM_REFRESH    = 5,
   parameter int          LAST_GFX_CYCLE = 54,
   parameter int          RESET_SPRITE   = 3,
   parameter logic [15:0] IDLE_PRE       = IDLE_PRE_DEF,
   parameter logic [15:0] IDLE_POST      = IDLE_POST_DEF
) (
   input logic        clk_dot4x,
   input logic        rst,
   cycle_seq_if.slave bus
);
   localparam int               SPR_W     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam logic [SPR_W-1:0] SPR_LAST  = SPR_W'(NUM_SPRITES - 1);
   localparam logic [SPR_W-1:0] SPR_RESET = SPR_W'(RESET_SPRITE);
   localparam logic [2:0]       REF_LAST  = 3'(NUM_REFRESH - 1);
   localparam logic [6:0]       GFX_LAST  = 7'(LAST_GFX_CYCLE);

   logic [3:0]       state_q, state_d;
   logic [SPR_W-1:0] sprite_cnt_q, sprite_cnt_d;
   logic [2:0]       refresh_cnt_q, refresh_cnt_d;
   logic [3:0]       idle_cnt_q, idle_cnt_d;
   logic [1:0]       chip_q, chip_d;
   logic             post_idle_q, post_idle_d;

   logic             advance;
   logic             idle_done;
   logic             ext_grant;
   logic [3:0]       pre_len;
   logic [3:0]       post_len;

   assign pre_len  = nibble_sel(IDLE_PRE, chip_q);
   assign post_len = nibble_sel(IDLE_POST, chip_q);

   // Low states leave on the phi=1 strobe, high states on the phi=0 strobe.
   assign advance = bus.phi_phase_start_0 &
                    (is_low_phase(state_q) ? bus.clk_phi : ~bus.clk_phi);

   always_comb begin
      state_d       = state_q;
      sprite_cnt_d  = sprite_cnt_q;
      refresh_cnt_d = refresh_cnt_q;
      idle_cnt_d    = idle_cnt_q;
      chip_d        = chip_q;
      post_idle_d   = post_idle_q;
      if (advance) begin
         case (state_q)
            VIC_LP:   state_d = bus.sprite_dma[sprite_cnt_q] ? VIC_HS1 : VIC_HPI1;
            VIC_HS1:  state_d = VIC_LS2;
            VIC_LS2:  state_d = VIC_HS3;
            VIC_HPI1: state_d = VIC_LPI2;
            VIC_LPI2: state_d = VIC_HPI3;
            VIC_HS3, VIC_HPI3: begin
               if (sprite_cnt_q != SPR_LAST) begin
                  sprite_cnt_d = sprite_cnt_q + 1'b1;
                  state_d      = VIC_LP;
               end else begin
                  sprite_cnt_d  = '0;
                  refresh_cnt_d = '0;
                  if (post_len == 4'd0) begin
                     state_d = VIC_LR;
                     chip_d  = bus.chip;
                  end else begin
                     state_d     = VIC_LI;
                     idle_cnt_d  = post_len - 4'd1;
                     post_idle_d = 1'b1;
                  end
               end
            end
            VIC_LR: begin
               if (refresh_cnt_q == REF_LAST) begin
                  state_d = bus.badline ? VIC_HRC : VIC_HRX;
               end else begin
                  state_d = VIC_HRI;
               end
            end
            VIC_HRI: begin
               refresh_cnt_d = refresh_cnt_q + 3'd1;
               state_d       = VIC_LR;
            end
            VIC_HRC, VIC_HRX: state_d = VIC_LG;
            VIC_LG: begin
               if (bus.cycle_num == GFX_LAST) begin
                  state_d     = VIC_HI;
                  idle_cnt_d  = 4'd0;
                  post_idle_d = 1'b0;
               end else begin
                  state_d = bus.badline ? VIC_HGC : VIC_HGI;
               end
            end
            VIC_HGC, VIC_HGI: state_d = VIC_LG;
            VIC_HI: begin
               if (idle_done) begin
                  if (post_idle_q) begin
                     state_d     = VIC_LR;
                     chip_d      = bus.chip;
                     post_idle_d = 1'b0;
                  end else begin
                     state_d = VIC_LP;
                  end
               end else begin
                  idle_cnt_d = post_idle_q ? (idle_cnt_q - 4'd1) : (idle_cnt_q + 4'd1);
                  state_d    = VIC_LI;
               end
            end
            VIC_LI:  state_d = VIC_HI;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         state_q       <= VIC_LP;
         sprite_cnt_q  <= SPR_RESET;
         refresh_cnt_q <= 3'd0;
         idle_cnt_q    <= nibble_sel(IDLE_PRE, bus.chip);
         chip_q        <= bus.chip;
         post_idle_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sprite_cnt_q  <= sprite_cnt_d;
         refresh_cnt_q <= refresh_cnt_d;
         idle_cnt_q    <= idle_cnt_d;
         chip_q        <= chip_d;
         post_idle_q   <= post_idle_d;
      end
   end

   idle_slot_arbiter u_idle_arb (
      .clk_dot4x   (clk_dot4x),
      .rst         (rst),
      .advance     (advance),
      .enter_li    (state_d == VIC_LI),
      .ext_req     (bus.ext_req),
      .post_idle   (post_idle_q),
      .idle_cnt    (idle_cnt_q),
      .idle_target (pre_len),
      .idle_done   (idle_done),
      .ext_grant   (ext_grant)
   );

   assign bus.cycle_type  = state_q;
   assign bus.sprite_cnt  = sprite_cnt_q;
   assign bus.refresh_cnt = refresh_cnt_q;
   assign bus.idle_cnt    = idle_cnt_q;
   assign bus.ext_grant   = ext_grant;
endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: directed half-cycle vectors push expected slot
// outputs into a queue; a monitor pops one entry per update strobe.
module tb_cycle_sequencer;
   import cycle_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cycle_seq_if #(.NUM_SPRITES(8)) bus ();

   cycle_sequencer #(
      .NUM_SPRITES    (8),
      .NUM_REFRESH    (5),
      .LAST_GFX_CYCLE (54),
      .RESET_SPRITE   (3),
      .IDLE_PRE       ({4'd2, 4'd3, 4'd3, 4'd2}),
      .IDLE_POST      ({4'd0, 4'd0, 4'd1, 4'd0})
   ) dut (
      .clk_dot4x (clk),
      .rst       (rst),
      .bus       (bus.slave)
   );

   typedef struct {
      int         id;
      logic [3:0] ct;
      int         spr;
      int         rf;
      int         idle;
      logic       gnt;
   } exp_t;

   exp_t       exp_q[$];
   int         n_cmp   = 0;
   int         n_bad   = 0;
   int         step_no = 0;
   logic       phi_next = 1'b0;
   logic [7:0] dma_pat = 8'b0000_1000;

   // One half-cycle: strobe on the first dot4x clock, three quiet clocks after.
   task automatic step(input logic [3:0] ct, input int spr, input int rf,
                       input int idle, input logic gnt, input logic r = 1'b0);
      exp_t e;
      @(negedge clk);
      rst                   = r;
      bus.phi_phase_start_0 = 1'b1;
      bus.clk_phi           = phi_next;
      e.id   = step_no;
      e.ct   = ct;
      e.spr  = spr;
      e.rf   = rf;
      e.idle = idle;
      e.gnt  = gnt;
      exp_q.push_back(e);
      step_no++;
      phi_next = ~phi_next;
      @(negedge clk);
      rst                   = 1'b0;
      bus.phi_phase_start_0 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic run_sprites(input int s0, input int s1, input int rf, input int idle);
      for (int s = s0; s <= s1; s++) begin
         step(dma_pat[s] ? VIC_HS1 : VIC_HPI1, s, rf, idle, 1'b0);
         step(dma_pat[s] ? VIC_LS2 : VIC_LPI2, s, rf, idle, 1'b0);
         step(dma_pat[s] ? VIC_HS3 : VIC_HPI3, s, rf, idle, 1'b0);
         if (s < 7) step(VIC_LP, s + 1, rf, idle, 1'b0);
      end
   endtask

   task automatic run_refresh(input int idle);
      for (int r = 0; r < 4; r++) begin
         step(VIC_HRI, 0, r, idle, 1'b0);
         step(VIC_LR, 0, r + 1, idle, 1'b0);
      end
   endtask

   // Monitor: outputs settle one dot4x clock after each update strobe.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (bus.phi_phase_start_0 === 1'b1) begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_update: got ct=%0d with no expectation queued", bus.cycle_type);
            end else begin
               e = exp_q.pop_front();
               if (bus.cycle_type !== e.ct || bus.sprite_cnt !== 3'(e.spr) ||
                   bus.refresh_cnt !== 3'(e.rf) || bus.idle_cnt !== 4'(e.idle) ||
                   bus.ext_grant !== e.gnt) begin
                  n_bad++;
                  $display("FAIL step%0d: got ct=%0d spr=%0d ref=%0d idle=%0d grant=%0b, want ct=%0d spr=%0d ref=%0d idle=%0d grant=%0b",
                           e.id, bus.cycle_type, bus.sprite_cnt, bus.refresh_cnt, bus.idle_cnt,
                           bus.ext_grant, e.ct, e.spr, e.rf, e.idle, e.gnt);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: stimulus did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      bus.chip              = CHIP_6569R3;
      bus.clk_phi           = 1'b0;
      bus.phi_phase_start_0 = 1'b0;
      bus.sprite_dma        = dma_pat;
      bus.badline           = 1'b0;
      bus.cycle_num         = 7'd0;
      bus.ext_req           = 1'b0;
      repeat (2) @(negedge clk);

      // Line 1: reset on 6569, sprites 3..7, refresh with badline, pre-idle of 2.
      step(VIC_LP, 3, 0, 2, 1'b0, 1'b1);
      run_sprites(3, 7, 0, 2);
      step(VIC_LR, 0, 0, 2, 1'b0);
      run_refresh(2);
      bus.badline = 1'b1;
      step(VIC_HRC, 0, 4, 2, 1'b0);
      step(VIC_LG, 0, 4, 2, 1'b0);
      step(VIC_HGC, 0, 4, 2, 1'b0);
      bus.chip      = CHIP_6567R56A;
      bus.ext_req   = 1'b1;
      bus.cycle_num = 7'd20;
      step(VIC_LG, 0, 4, 2, 1'b0);
      step(VIC_HGC, 0, 4, 2, 1'b0);
      step(VIC_LG, 0, 4, 2, 1'b0);
      bus.cycle_num = 7'd54;
      step(VIC_HI, 0, 4, 0, 1'b0);
      bus.cycle_num = 7'd0;
      bus.badline   = 1'b0;
      step(VIC_LI, 0, 4, 1, 1'b1);
      step(VIC_HI, 0, 4, 1, 1'b0);
      step(VIC_LI, 0, 4, 2, 1'b1);
      step(VIC_HI, 0, 4, 2, 1'b0);
      step(VIC_LP, 0, 4, 2, 1'b0);

      // Line 2: full sprite block, chip change lands at LR, pre-idle of 3.
      run_sprites(0, 7, 4, 2);
      step(VIC_LR, 0, 0, 2, 1'b0);
      run_refresh(2);
      step(VIC_HRX, 0, 4, 2, 1'b0);
      step(VIC_LG, 0, 4, 2, 1'b0);
      step(VIC_HGI, 0, 4, 2, 1'b0);
      step(VIC_LG, 0, 4, 2, 1'b0);
      bus.cycle_num = 7'd54;
      step(VIC_HI, 0, 4, 0, 1'b0);
      bus.cycle_num = 7'd0;
      step(VIC_LI, 0, 4, 1, 1'b1);
      step(VIC_HI, 0, 4, 1, 1'b0);
      bus.ext_req = 1'b0;
      step(VIC_LI, 0, 4, 2, 1'b0);
      bus.ext_req = 1'b1;
      step(VIC_HI, 0, 4, 2, 1'b0);
      step(VIC_LI, 0, 4, 3, 1'b1);
      step(VIC_HI, 0, 4, 3, 1'b0);
      step(VIC_LP, 0, 4, 3, 1'b0);

      // Line 3: reset during HS3 of sprite 3 on R8, then post-idle before refresh.
      run_sprites(0, 2, 4, 3);
      step(VIC_HS1, 3, 4, 3, 1'b0);
      step(VIC_LS2, 3, 4, 3, 1'b0);
      step(VIC_HS3, 3, 4, 3, 1'b0);
      bus.chip = CHIP_6567R8;
      step(VIC_LP, 3, 0, 3, 1'b0, 1'b1);
      run_sprites(3, 7, 0, 3);
      step(VIC_LI, 0, 0, 0, 1'b1);
      step(VIC_HI, 0, 0, 0, 1'b0);
      step(VIC_LR, 0, 0, 0, 1'b0);
      step(VIC_HRI, 0, 0, 0, 1'b0);
      step(VIC_LR, 0, 1, 0, 1'b0);

      repeat (8) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL leftover: %0d expectations never observed, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Parametrised successor to the per-line VIC cycle-type FSM.
- Generates the sequence of memory-access slots per raster line:
  - sprite pointer/data slots (P, S1–S3)
  - refresh slots (R)
  - graphics/char slots (G/C)
  - idle slots (I)
- Generalised over sprite count, refresh count, last graphics cycle and per-chip idle placement.
- Adds an idle-slot grant handshake so extension DMA (blitter, extra video fetch) can claim idle low phases.
- Sits beside the raster/bus-access logic; its outputs drive address generation and bus muxing.

Parameters:
- NUM_SPRITES, 8, number of sprite slots per line (2..16).
- NUM_REFRESH, 5, refresh slots per line; the last one doubles as first c-access decision slot.
- LAST_GFX_CYCLE, 54, cycle_num at which the final LG exits to idle.
- RESET_SPRITE, 3, sprite_cnt loaded on reset.
- IDLE_PRE, {4'd2,4'd3,4'd3,4'd2}, packed 4x4, indexed by chip: extra HI slots between LAST_GFX_CYCLE and sprite RESET_SPRITE... sprite 0 region.
- IDLE_POST, {4'd0,4'd0,4'd1,4'd0}, packed 4x4, indexed by chip: idle slot pairs inserted after the last sprite, before refresh.

Ports:
- clk_dot4x in 1 dot clock x4
- rst in 1 synchronous, active-high reset
- chip in 2 chip model code
- clk_phi in 1 current phi level
- phi_phase_start_0 in 1 update strobe, phase 0 of each half-cycle
- sprite_dma in NUM_SPRITES per-sprite DMA enable
- badline in 1 valid when phi_phase_start_0=1
- cycle_num in 7 current cycle within line
- ext_req in 1 extension DMA request
- cycle_type out 4 slot type, `VIC_* codes
- sprite_cnt out clog2(NUM_SPRITES) current sprite slot
- refresh_cnt out 3 current refresh slot
- idle_cnt out 4 idle counter
- ext_grant out 1 extension owns current low phase

Behaviour:
- Clocking and latency
  - All state changes only on clk_dot4x edges with phi_phase_start_0=1.
  - Registered outputs are visible the following clk_dot4x.
  - clk_phi=1 updates leave low-phase states (Lx→Hx).
  - clk_phi=0 updates leave high-phase states (Hx→Lx).
- Reset (synchronous, rst=1)
  - cycle_type=`VIC_LP, sprite_cnt=RESET_SPRITE, refresh_cnt=0, idle_cnt=IDLE_PRE[chip], ext_grant=0.
  - chip_q<=chip.
  - rst asserted mid-line fully overrides any update on the same edge.
- Chip latching
  - chip_q also reloads on every entry to LR from the sprite or post-idle path.
  - A chip change mid-line therefore takes effect at the next refresh block only.
- Sprite slots
  - LP: sprite_dma[sprite_cnt] ? HS1 : HPI1.
  - Then HS1→LS2→HS3, or HPI1→LPI2→HPI3.
  - At HS3/HPI3 with sprite_cnt < NUM_SPRITES-1: sprite_cnt++, go to LP.
  - At HS3/HPI3 with sprite_cnt = NUM_SPRITES-1: sprite_cnt=0, refresh_cnt=0, then:
    - IDLE_POST[chip_q]=0 → LR.
    - otherwise → LI, with idle_cnt loaded to IDLE_POST[chip_q]-1 and flagged post-idle.
- Refresh
  - LR: refresh_cnt=NUM_REFRESH-1 ? (badline ? HRC : HRX) : HRI.
  - HRI→LR with refresh_cnt++.
  - HRC/HRX→LG.
- Graphics
  - LG: cycle_num=LAST_GFX_CYCLE → HI with idle_cnt=0 (pre-idle).
  - Otherwise LG → HGC if badline, else HGI; both return to LG.
- Idle
  - Pre-idle HI: idle_cnt=IDLE_PRE[chip_q] → LP. Otherwise idle_cnt++ and → LI.
  - Post-idle HI: idle_cnt=0 → LR. Otherwise idle_cnt-- and → LI.
  - LI→HI.
- ext_grant
  - Set on the Hx→LI update when ext_req=1.
  - Cleared on the next update (LI→HI).
  - Never asserted in any non-LI state; ext_req is ignored elsewhere.
- Widths
  - sprite_cnt and refresh_cnt wrap only by the explicit reloads above, never by natural overflow.
  - Unused cycle_type codes hold state; no recovery is required beyond rst.

Decomposition:
- Shared package/header:
  - `VIC_* cycle-type codes
  - chip codes
  - `NUM_SPRITES default
  - IDLE_PRE/IDLE_POST default vectors
- One sub-module, idle_slot_arbiter: ext_req→ext_grant logic plus the idle_cnt compare.
- Main FSM stays in cycle_sequencer.

Test Plan:
- Reset: rst=1 with chip=6569 → LP, sprite_cnt=3, idle_cnt=2, ext_grant=0 one clk_dot4x later.
- Sprite slots, sprite_dma=8'b0000_1000, NUM_SPRITES=8:
  - sprite 3 yields LP,HS1,LS2,HS3.
  - Sprites 4..7 yield LP,HPI1,LPI2,HPI3.
  - Then LR with refresh_cnt=0.
- R8 (IDLE_POST=1): after sprite 7 HPI3 → LI, HI, LR.
  - End of line, LAST_GFX_CYCLE=54: LG at 54 → HI, LI, HI, LI, HI, LI, HI (4 HI), then LP.
- Refresh, badline=1 at the 5th refresh: LR,HRI x4, then LR → HRC → LG → HGC.
  - Same with badline=0 → HRX, HGI.
- Extension grant:
  - ext_req=1 held during pre-idle → ext_grant high exactly during each LI.
  - ext_grant stays 0 during LP/LR/LG.
- Mid-operation events:
  - chip change 6569→R56A during LG → pre-idle still uses IDLE_PRE=2 until the next LR.
  - rst pulse mid-HS3 → LP/RESET_SPRITE on the next clk_dot4x.
